regfile_read_arbiter: RTL and testbench

Shares one read port of the 16×16 register file among NUM_REQ requesters, such as decode operand fetch, debug and the halt/dump unit. Each cycle it grants at most one requester, round-robin. It drives the register index onto the read port, whose 4→16 wordline decoder and combinational array return data in the same cycle. It returns the data through a one-entry registered response stage with valid/ready backpressure. A same-cycle write to the selected register is bypassed, so readers see write-before-read semantics.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/regfile_read_arbiter.sv | 95 +++++++++
 tb/tb_regfile_read_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register file types and sizes for the read/write port arbiters.
// No logic; types and a tag-width helper only.
package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;

  typedef logic [ADDR_W-1:0] regid_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans from last+1 with wrap, combinational (0 cycles).
// No storage; en low suppresses every grant, so backpressure is the caller's.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = tag_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sel     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = IDX_W'((int'(last) + k) % NUM_REQ);
      if (en && !gnt_vld && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register file read port among NUM_REQ requesters; response 1 cycle after grant.
// A held, unaccepted response blocks all grants; accept and new grant may share an edge.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = $bits(regid_t),
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int TAG_W   = tag_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_regid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rf_regid,
  output logic                      rf_rd_en,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_regid,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      rsp_valid,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      rsp_ready
);

  rsp_state_e          state, state_nxt;
  logic [TAG_W-1:0]    last;
  logic                stall;
  logic                arb_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [TAG_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic [DATA_W-1:0]   byp_data;

  assign rsp_valid = (state == RSP_FULL);
  assign stall     = rsp_valid & ~rsp_ready;
  // Reset gating keeps grants off while rst is held, not just after the edge.
  assign arb_en    = ~stall & ~rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_rr (
    .req     (req_valid),
    .en      (arb_en),
    .last    (last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_ready = gnt;
  assign rf_rd_en  = gnt_vld;

  always_comb begin
    rf_regid = req_regid[ADDR_W-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) rf_regid = req_regid[i*ADDR_W +: ADDR_W];
    end
  end

  // Write-before-read: a write landing this cycle wins over the array's old value.
  assign byp_data = (wr_en && (wr_regid == rf_regid)) ? wr_data : rf_data;

  always_comb begin
    state_nxt = state;
    case (state)
      RSP_EMPTY: if (gnt_vld) state_nxt = RSP_FULL;
      RSP_FULL: begin
        if (gnt_vld)        state_nxt = RSP_FULL;
        else if (rsp_ready) state_nxt = RSP_EMPTY;
      end
      default:              state_nxt = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RSP_EMPTY;
      last     <= TAG_W'(NUM_REQ - 1);
      rsp_tag  <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        last     <= gnt_idx;
        rsp_tag  <= gnt_idx;
        rsp_data <= byp_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed stimulus pushes expected responses; a negedge monitor pops them on each accept.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_regid;
  logic [3:0]  req_ready;
  logic [3:0]  rf_regid;
  logic        rf_rd_en;
  logic [15:0] rf_data;
  logic        wr_en;
  logic [3:0]  wr_regid;
  logic [15:0] wr_data;
  logic        rsp_valid;
  logic [1:0]  rsp_tag;
  logic [15:0] rsp_data;
  logic        rsp_ready;

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_read_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_regid (req_regid),
    .req_ready (req_ready),
    .rf_regid  (rf_regid),
    .rf_rd_en  (rf_rd_en),
    .rf_data   (rf_data),
    .wr_en     (wr_en),
    .wr_regid  (wr_regid),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle in which a grant is required; the response is queued for the monitor.
  task automatic grant_cycle(input string nm, input logic [3:0] exp_rdy, input logic [1:0] tag,
                             input logic [3:0] exp_regid, input logic [15:0] exp_data);
    exp_t e;
    @(negedge clk);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({nm, "_rf_rd_en"}, 32'(rf_rd_en), 32'd1);
    chk({nm, "_rf_regid"}, 32'(rf_regid), 32'(exp_regid));
    e.tag  = tag;
    e.data = exp_data;
    exp_q.push_back(e);
    step();
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected tag=%0d data=%h at %0t", rsp_tag, rsp_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rsp_tag !== e.tag || rsp_data !== e.data) begin
          errors++;
          $display("FAIL rsp_compare got tag=%0d data=%h exp tag=%0d data=%h at %0t",
                   rsp_tag, rsp_data, e.tag, e.data, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_regid = '0; rf_data = '0;
    wr_en = 1'b0; wr_regid = '0; wr_data = '0; rsp_ready = 1'b0;
    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    step();

    // Round-robin from reset: 0,1,2,3,0
    rst = 1'b0; rsp_ready = 1'b1; req_regid = 16'h3333; rf_data = 16'hAAAA;
    for (int i = 0; i < 5; i++)
      grant_cycle("rr_order", 4'(1 << (i % 4)), 2'(i % 4), 4'd3, 16'hAAAA);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd0);
    chk("idle_rf_rd_en", 32'(rf_rd_en), 32'd0);
    chk("idle_rf_regid", 32'(rf_regid), 32'd3);
    step();

    // Backpressure: one grant, then held for 5 cycles while rf_data moves
    rsp_ready = 1'b0; req_valid = 4'b0010; req_regid = 16'h0070; rf_data = 16'h5555;
    grant_cycle("bp_first", 4'b0010, 2'd1, 4'd7, 16'h5555);
    rf_data = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rf_rd_en", 32'(rf_rd_en), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_tag", 32'(rsp_tag), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h5555);
      step();
    end
    rsp_ready = 1'b1;
    grant_cycle("bp_release", 4'b0010, 2'd1, 4'd7, 16'h0F0F);
    req_valid = 4'b0000;
    step();

    // Bypass on matching write index, none on a different index
    req_valid = 4'b0001; req_regid = 16'h0005; rf_data = 16'h0000;
    wr_en = 1'b1; wr_regid = 4'd5; wr_data = 16'h1234;
    grant_cycle("bypass_hit", 4'b0001, 2'd0, 4'd5, 16'h1234);
    wr_regid = 4'd6;
    grant_cycle("bypass_miss", 4'b0001, 2'd0, 4'd5, 16'h0000);
    wr_en = 1'b0; req_valid = 4'b0000;
    step();

    // A held response ignores later writes to its register
    rsp_ready = 1'b0; req_valid = 4'b0001; rf_data = 16'h7777;
    grant_cycle("held", 4'b0001, 2'd0, 4'd5, 16'h7777);
    req_valid = 4'b0000; wr_en = 1'b1; wr_regid = 4'd5; wr_data = 16'hBEEF; rf_data = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("held_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("held_rsp_data", 32'(rsp_data), 32'h7777);
      step();
    end
    wr_en = 1'b0; rsp_ready = 1'b1;
    step();

    // Reset while FULL: response discarded asynchronously
    rsp_ready = 1'b0; req_valid = 4'b0100; req_regid = 16'h0200; rf_data = 16'h1111;
    @(negedge clk);
    chk("pre_rst_req_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("async_rst_rsp_data", 32'(rsp_data), 32'd0);
    req_valid = 4'b1001;
    #1;
    chk("in_rst_req_ready", 32'(req_ready), 32'd0);
    step();

    // Sparse requesters after reset: 0,3,0,3
    rst = 1'b0; rsp_ready = 1'b1; req_regid = 16'h9004;
    for (int i = 0; i < 4; i++) begin
      rf_data = 16'(16'h1000 * (i + 1));
      if (i % 2 == 0) grant_cycle("sparse", 4'b0001, 2'd0, 4'd4, rf_data);
      else            grant_cycle("sparse", 4'b1000, 2'd3, 4'd9, rf_data);
    end
    req_valid = 4'b0000;
    step();
    step();
    @(negedge clk);
    chk("final_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
